// File: rtl/bf_pkg.sv
// Shared types and constants for the Bellman-Ford pipeline sequencer.
package bf_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_RUN      = 3'd2,
        S_DRAIN    = 3'd3,
        S_PASS_END = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // Distance word width and the "unreached" value the datapath writes
    // when init_zero is low.
    localparam int DIST_W = 16;
    localparam logic [DIST_W-1:0] DIST_INF = '1;

endpackage

// File: rtl/bf_hazard_unit.sv
// Read-after-write hazard detector.
// The edge in Read may depend on a distance that Relax or Write is
// about to change. If so, the edge must wait.
module bf_hazard_unit #(
    parameter int NODE_AW = 8
) (
    input  logic               v1,
    input  logic               v2,
    input  logic               v3,
    input  logic [NODE_AW-1:0] rd_src,
    input  logic [NODE_AW-1:0] rd_dst,
    input  logic [NODE_AW-1:0] x_dst,
    input  logic               x_upd,
    input  logic [NODE_AW-1:0] w_dst,
    input  logic               w_upd,
    output logic               stall
);

    logic x_hit;
    logic w_hit;

    // Compare the Read-stage nodes against the pending Relax and Write targets.
    always_comb begin
        x_hit = v2 & x_upd & ((x_dst == rd_src) | (x_dst == rd_dst));
        w_hit = v3 & w_upd & ((w_dst == rd_src) | (w_dst == rd_dst));
        stall = v1 & (x_hit | w_hit);
    end

endmodule

// File: rtl/bf_pipe_ctrl.sv
// Sequencer for the pipelined Bellman-Ford datapath.
// Function:
//   - Initialises the distance memory.
//   - Streams edge addresses into Fetch.
//   - Steers the R1..R3 enables and clears.
//   - Inserts bubbles on read-after-write hazards.
//   - Counts passes and flags a negative cycle.
// Register handshake:
//   - reg_en[i] moves stage i's data into R(i+1).
//   - reg_clr[i] overrides the enable and empties R(i+1).
//   - A valid bit follows each register, so a held register keeps its occupancy.
module bf_pipe_ctrl
    import bf_pkg::*;
#(
    parameter int NODE_AW  = 8,
    parameter int EDGE_AW  = 10,
    parameter int SRC_NODE = 0
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [NODE_AW:0]   num_nodes,
    input  logic [EDGE_AW:0]   num_edges,
    output logic               init_we,
    output logic [NODE_AW-1:0] init_addr,
    output logic               init_zero,
    output logic [EDGE_AW-1:0] edge_addr,
    output logic [2:0]         reg_en,
    output logic [2:0]         reg_clr,
    input  logic [NODE_AW-1:0] rd_src,
    input  logic [NODE_AW-1:0] rd_dst,
    input  logic [NODE_AW-1:0] x_dst,
    input  logic               x_upd,
    input  logic [NODE_AW-1:0] w_dst,
    input  logic               w_upd,
    output logic [NODE_AW:0]   pass_cnt,
    output logic               busy,
    output logic               done,
    output logic               neg_cycle
);

    localparam logic [NODE_AW:0]   NODE_ONE  = 1;
    localparam logic [EDGE_AW:0]   EDGE_ONE  = 1;
    localparam logic [NODE_AW-1:0] ADDR_ONE  = 1;
    localparam logic [EDGE_AW-1:0] EADDR_ONE = 1;
    localparam logic [NODE_AW-1:0] SRC_ADDR  = NODE_AW'(SRC_NODE);

    state_t             state;
    state_t             state_nxt;
    logic [NODE_AW:0]   v_reg;
    logic [EDGE_AW:0]   e_reg;
    logic               v1, v2, v3;
    logic               any_upd;
    logic               is_check;
    logic               stall_raw;
    logic               stall;
    logic               in_pipe;
    logic               init_last;
    logic               issue_last;
    logic               pipe_empty;
    logic               go_check;
    logic               fetch_valid;
    logic [NODE_AW:0]   pass_inc;
    logic [NODE_AW-1:0] init_addr_inc;

    bf_hazard_unit #(.NODE_AW(NODE_AW)) u_hazard (
        .v1     (v1),
        .v2     (v2),
        .v3     (v3),
        .rd_src (rd_src),
        .rd_dst (rd_dst),
        .x_dst  (x_dst),
        .x_upd  (x_upd),
        .w_dst  (w_dst),
        .w_upd  (w_upd),
        .stall  (stall_raw)
    );

    // Terminal conditions.
    // Counters are one bit wider than the addresses, so N-1 never wraps.
    always_comb begin
        in_pipe       = (state == S_RUN) || (state == S_DRAIN);
        stall         = stall_raw & in_pipe;
        init_last     = ({1'b0, init_addr} == (v_reg - NODE_ONE));
        issue_last    = ({1'b0, edge_addr} == (e_reg - EDGE_ONE));
        pipe_empty    = !v1 && !v2 && !v3;
        pass_inc      = pass_cnt + NODE_ONE;
        go_check      = (pass_inc >= (v_reg - NODE_ONE));
        fetch_valid   = (state == S_RUN) && !stall;
        init_addr_inc = init_addr + ADDR_ONE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clear) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_INIT;
            S_INIT:     if (init_last) state_nxt = (e_reg == '0) ? S_PASS_END : S_RUN;
            S_RUN:      if (!stall && issue_last) state_nxt = S_DRAIN;
            S_DRAIN:    if (pipe_empty) state_nxt = S_PASS_END;
            S_PASS_END: state_nxt = (is_check || !any_upd) ? S_DONE : S_RUN;
            S_DONE:     if (start) state_nxt = S_INIT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Pipeline register controls and the busy flag.
    always_comb begin
        reg_en  = 3'b000;
        reg_clr = 3'b000;
        busy    = (state != S_IDLE) && (state != S_DONE);
        if (clear || state == S_IDLE) begin
            reg_clr = 3'b111;
        end else if (in_pipe) begin
            if (stall) begin
                // R1 holds, a bubble enters R2, R3 keeps draining.
                reg_en  = 3'b110;
                reg_clr = 3'b010;
            end else begin
                reg_en  = 3'b111;
            end
        end
    end

    // Occupancy tracking. Each valid bit shifts with its register's enable.
    always_ff @(posedge clk) begin
        if (clear) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (reg_clr[0])     v1 <= 1'b0;
            else if (reg_en[0]) v1 <= fetch_valid;
            if (reg_clr[1])     v2 <= 1'b0;
            else if (reg_en[1]) v2 <= v1;
            if (reg_clr[2])     v3 <= 1'b0;
            else if (reg_en[2]) v3 <= v2;
        end
    end

    // Counters, address generators and result flags.
    always_ff @(posedge clk) begin
        if (clear) begin
            init_we   <= 1'b0;
            init_addr <= '0;
            init_zero <= 1'b0;
            edge_addr <= '0;
            pass_cnt  <= '0;
            done      <= 1'b0;
            neg_cycle <= 1'b0;
            v_reg     <= '0;
            e_reg     <= '0;
            any_upd   <= 1'b0;
            is_check  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        init_we   <= 1'b1;
                        init_addr <= '0;
                        init_zero <= (SRC_ADDR == '0);
                        edge_addr <= '0;
                        pass_cnt  <= '0;
                        done      <= 1'b0;
                        neg_cycle <= 1'b0;
                        v_reg     <= num_nodes;
                        e_reg     <= num_edges;
                        any_upd   <= 1'b0;
                        is_check  <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (init_last) begin
                        init_we   <= 1'b0;
                        init_zero <= 1'b0;
                    end else begin
                        init_addr <= init_addr_inc;
                        init_zero <= (init_addr_inc == SRC_ADDR);
                    end
                end
                S_RUN, S_DRAIN: begin
                    any_upd <= any_upd | (w_upd & v3);
                    if (state == S_RUN && !stall && !issue_last)
                        edge_addr <= edge_addr + EADDR_ONE;
                end
                S_PASS_END: begin
                    if (is_check) begin
                        done      <= 1'b1;
                        neg_cycle <= any_upd;
                    end else if (!any_upd) begin
                        done      <= 1'b1;
                        neg_cycle <= 1'b0;
                    end else begin
                        pass_cnt  <= pass_inc;
                        is_check  <= go_check;
                        any_upd   <= 1'b0;
                        edge_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_pipe_ctrl.sv
// Directed bench for bf_pipe_ctrl.
// Covers reset, init sequencing, edge streaming, pass counting,
// hazard stalls, negative-cycle detection, mid-run clear and ignored start.
module tb_bf_pipe_ctrl;

    localparam int NODE_AW = 8;
    localparam int EDGE_AW = 10;

    logic               clk = 1'b0;
    logic               clear;
    logic               start;
    logic [NODE_AW:0]   num_nodes;
    logic [EDGE_AW:0]   num_edges;
    logic               init_we;
    logic [NODE_AW-1:0] init_addr;
    logic               init_zero;
    logic [EDGE_AW-1:0] edge_addr;
    logic [2:0]         reg_en;
    logic [2:0]         reg_clr;
    logic [NODE_AW-1:0] rd_src;
    logic [NODE_AW-1:0] rd_dst;
    logic [NODE_AW-1:0] x_dst;
    logic               x_upd;
    logic [NODE_AW-1:0] w_dst;
    logic               w_upd;
    logic [NODE_AW:0]   pass_cnt;
    logic               busy;
    logic               done;
    logic               neg_cycle;

    int n_assert = 0;
    int n_fail   = 0;

    bf_pipe_ctrl #(.NODE_AW(NODE_AW), .EDGE_AW(EDGE_AW), .SRC_NODE(0)) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .num_nodes (num_nodes),
        .num_edges (num_edges),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_zero (init_zero),
        .edge_addr (edge_addr),
        .reg_en    (reg_en),
        .reg_clr   (reg_clr),
        .rd_src    (rd_src),
        .rd_dst    (rd_dst),
        .x_dst     (x_dst),
        .x_upd     (x_upd),
        .w_dst     (w_dst),
        .w_upd     (w_upd),
        .pass_cnt  (pass_cnt),
        .busy      (busy),
        .done      (done),
        .neg_cycle (neg_cycle)
    );

    // Clock.
    always #5 clk = ~clk;

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before time limit");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pulse start for one edge.
    task automatic launch(input int v, input int e);
        num_nodes = (NODE_AW+1)'(v);
        num_edges = (EDGE_AW+1)'(e);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for done with a bounded cycle budget, checking the cycle count.
    task automatic wait_done(input int exp_cycles, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; num_nodes = '0; num_edges = '0;
        rd_src = 8'd1; rd_dst = 8'd2; x_dst = 8'd0; x_upd = 1'b0;
        w_dst = 8'd7; w_upd = 1'b0;
        tick();
        tick();

        // Reset state, with clear still high.
        chk("rst_busy",    32'(busy), 0);
        chk("rst_done",    32'(done), 0);
        chk("rst_reg_en",  32'(reg_en), 0);
        chk("rst_reg_clr", 32'(reg_clr), 32'h7);
        chk("rst_edge",    32'(edge_addr), 0);
        chk("rst_pass",    32'(pass_cnt), 0);
        chk("rst_init_we", 32'(init_we), 0);
        clear = 1'b0;
        tick();
        chk("idle_reg_clr", 32'(reg_clr), 32'h7);

        // V=4, E=0: four init writes, then done with no passes.
        launch(4, 0);
        for (int a = 0; a < 4; a++) begin
            chk("e0_init_we",   32'(init_we), 1);
            chk("e0_init_addr", 32'(init_addr), 32'(a));
            chk("e0_init_zero", 32'(init_zero), (a == 0) ? 1 : 0);
            chk("e0_busy",      32'(busy), 1);
            chk("e0_reg_en",    32'(reg_en), 0);
            tick();
        end
        chk("e0_init_off", 32'(init_we), 0);
        wait_done(1, "e0");
        chk("e0_pass", 32'(pass_cnt), 0);
        chk("e0_neg",  32'(neg_cycle), 0);
        chk("e0_busy_done", 32'(busy), 0);
        chk("e0_reg_clr_done", 32'(reg_clr), 0);

        // V=3, E=3: updates in pass 1 only.
        w_upd = 1'b1;
        launch(3, 3);
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("chain_edge",    32'(edge_addr), 32'(i));
            chk("chain_reg_en",  32'(reg_en), 32'h7);
            chk("chain_reg_clr", 32'(reg_clr), 0);
            tick();
        end
        chk("chain_drain_edge", 32'(edge_addr), 2);
        tick(); tick(); tick(); tick();
        chk("chain_pass_end_cnt", 32'(pass_cnt), 0);
        w_upd = 1'b0;
        tick();
        chk("chain_pass2_cnt",  32'(pass_cnt), 1);
        chk("chain_pass2_edge", 32'(edge_addr), 0);
        chk("chain_pass2_done", 32'(done), 0);
        wait_done(8, "chain");
        chk("chain_pass", 32'(pass_cnt), 1);
        chk("chain_neg",  32'(neg_cycle), 0);

        // V=3, E=3: updates every pass, so the check pass flags a negative cycle.
        w_upd = 1'b1;
        launch(3, 3);
        chk("neg_done_cleared", 32'(done), 0);
        chk("neg_pass_cleared", 32'(pass_cnt), 0);
        wait_done(27, "neg");
        chk("neg_pass", 32'(pass_cnt), 2);
        chk("neg_flag", 32'(neg_cycle), 1);
        w_upd = 1'b0;

        // V=1, E=1: one init write, one pass, done.
        launch(1, 1);
        chk("v1_init_we",   32'(init_we), 1);
        chk("v1_init_zero", 32'(init_zero), 1);
        wait_done(7, "v1");
        chk("v1_pass", 32'(pass_cnt), 0);
        chk("v1_neg",  32'(neg_cycle), 0);

        // Hazard: Relax-stage conflict, then Write-stage conflict, then resume.
        launch(2, 16);
        tick(); tick();
        chk("hz_edge0", 32'(edge_addr), 0);
        tick();
        chk("hz_edge1", 32'(edge_addr), 1);
        tick();
        rd_src = 8'd5; x_dst = 8'd5; x_upd = 1'b1;
        #1;
        chk("hz_x_reg_en",  32'(reg_en), 32'h6);
        chk("hz_x_reg_clr", 32'(reg_clr), 32'h2);
        chk("hz_x_edge",    32'(edge_addr), 2);
        tick();
        x_upd = 1'b0; w_dst = 8'd5; w_upd = 1'b1;
        #1;
        chk("hz_w_edge",    32'(edge_addr), 2);
        chk("hz_w_reg_en",  32'(reg_en), 32'h6);
        chk("hz_w_reg_clr", 32'(reg_clr), 32'h2);
        tick();
        #1;
        chk("hz_resume_reg_en",  32'(reg_en), 32'h7);
        chk("hz_resume_reg_clr", 32'(reg_clr), 0);
        chk("hz_resume_edge",    32'(edge_addr), 2);
        w_upd = 1'b0; rd_src = 8'd1; w_dst = 8'd7;
        tick();
        chk("hz_edge3", 32'(edge_addr), 3);

        // start during RUN is ignored.
        launch(4, 2);
        chk("ign_edge",    32'(edge_addr), 4);
        chk("ign_busy",    32'(busy), 1);
        chk("ign_init_we", 32'(init_we), 0);
        chk("ign_pass",    32'(pass_cnt), 0);
        tick(); tick(); tick();
        chk("clr_edge_before", 32'(edge_addr), 7);

        // Clear mid-RUN.
        clear = 1'b1;
        #1;
        chk("clr_now_reg_en",  32'(reg_en), 0);
        chk("clr_now_reg_clr", 32'(reg_clr), 32'h7);
        tick();
        clear = 1'b0;
        #1;
        chk("clr_busy",    32'(busy), 0);
        chk("clr_edge",    32'(edge_addr), 0);
        chk("clr_reg_clr", 32'(reg_clr), 32'h7);
        chk("clr_reg_en",  32'(reg_en), 0);
        chk("clr_pass",    32'(pass_cnt), 0);
        chk("clr_done",    32'(done), 0);

        // Restart after clear.
        tick();
        launch(2, 1);
        chk("re_init_we0",   32'(init_we), 1);
        chk("re_init_addr0", 32'(init_addr), 0);
        chk("re_init_zero0", 32'(init_zero), 1);
        tick();
        chk("re_init_addr1", 32'(init_addr), 1);
        chk("re_init_zero1", 32'(init_zero), 0);
        tick();
        chk("re_init_off", 32'(init_we), 0);
        chk("re_edge",     32'(edge_addr), 0);
        chk("re_reg_en",   32'(reg_en), 32'h7);
        wait_done(6, "re");
        chk("re_pass", 32'(pass_cnt), 0);
        chk("re_neg",  32'(neg_cycle), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
